// File: rtl/fractal_pkg.sv
// Shared types and default constants for the fractal frame sequencer.
package fractal_pkg;

  typedef logic signed [31:0] param_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    param_t x0;
    param_t y0;
    param_t dx;
    param_t dy;
    param_t cr;
    param_t ci;
    param_t dcr;
    param_t dci;
  } param_set_t;

  localparam int unsigned DefHeight      = 1080;
  localparam int unsigned DefResetCycles = 2;

endpackage

// File: rtl/fractal_param_shadow.sv
// Shadow/active parameter register pair: host writes land in the shadow set and only
// reach the generator-facing active set on frame load or frame boundary.
module fractal_param_shadow
  import fractal_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       update_i,
  input  param_set_t cfg_i,
  input  logic       start_i,
  input  logic       load_i,
  input  logic       step_i,
  output param_set_t active_o
);

  param_set_t shadow_q, shadow_d;
  param_set_t active_q, active_d;
  logic       pending_q, pending_d;

  always_comb begin
    shadow_d  = update_i ? cfg_i : shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (load_i) begin
      active_d = shadow_q;
      // cr/ci carry the per-frame sweep unless fresh base values are waiting
      if (!pending_q) begin
        active_d.cr = active_q.cr;
        active_d.ci = active_q.ci;
      end
      pending_d = 1'b0;
    end else if (start_i) begin
      active_d.cr = shadow_q.cr;
      active_d.ci = shadow_q.ci;
    end else if (step_i) begin
      if (pending_q) begin
        active_d.cr = shadow_q.cr;
        active_d.ci = shadow_q.ci;
      end else begin
        active_d.cr = active_q.cr + active_q.dcr;
        active_d.ci = active_q.ci + active_q.dci;
      end
    end
    if (update_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/fractal_frame_sequencer.sv
// Frame sequencer: holds the generator in reset between frames, counts output lines
// and steps the Julia constant (cr, ci) once per completed frame.
module fractal_frame_sequencer
  import fractal_pkg::*;
#(
  parameter int unsigned HEIGHT       = DefHeight,
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned FRAME_CNT_W  = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cfg_enable,
  input  logic                   cfg_update,
  input  logic signed [31:0]     cfg_x0,
  input  logic signed [31:0]     cfg_y0,
  input  logic signed [31:0]     cfg_dx,
  input  logic signed [31:0]     cfg_dy,
  input  logic signed [31:0]     cfg_cr,
  input  logic signed [31:0]     cfg_ci,
  input  logic signed [31:0]     cfg_dcr,
  input  logic signed [31:0]     cfg_dci,
  input  logic [FRAME_CNT_W-1:0] cfg_num_frames,
  input  logic                   s_valid,
  input  logic                   s_ready,
  input  logic                   s_line_end,
  output logic                   gen_resetn,
  output logic signed [31:0]     gen_x0,
  output logic signed [31:0]     gen_y0,
  output logic signed [31:0]     gen_dx,
  output logic signed [31:0]     gen_dy,
  output logic signed [31:0]     gen_cr,
  output logic signed [31:0]     gen_ci,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned LineW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned RstW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [LineW-1:0]       line_q, line_d;
  logic [RstW-1:0]        rst_cnt_q, rst_cnt_d;
  logic                   first_q, first_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d, frame_count_inc;
  logic                   frame_done_q, frame_done_d;
  logic                   gen_resetn_q, busy_q;
  logic                   beat, start, boundary;
  param_set_t             cfg_set, active;

  assign beat            = s_valid & s_ready & s_line_end;
  assign frame_count_inc = frame_count_q + FRAME_CNT_W'(1);

  assign cfg_set = '{x0: cfg_x0, y0: cfg_y0, dx: cfg_dx, dy: cfg_dy,
                     cr: cfg_cr, ci: cfg_ci, dcr: cfg_dcr, dci: cfg_dci};

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    rst_cnt_d     = rst_cnt_q;
    first_d       = 1'b0;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    start         = 1'b0;
    boundary      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_enable) begin
          state_d       = StLoad;
          start         = 1'b1;
          first_d       = 1'b1;
          rst_cnt_d     = RstW'(RESET_CYCLES - 1);
          frame_count_d = '0;
        end
      end
      StLoad: begin
        line_d = '0;
        if (rst_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q - RstW'(1);
        end
      end
      StRun, StDrain: begin
        if (beat && (line_q == LineW'(HEIGHT - 1))) begin
          boundary      = 1'b1;
          line_d        = '0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_inc;
          if ((state_q == StDrain) || !cfg_enable ||
              ((cfg_num_frames != '0) && (frame_count_inc == cfg_num_frames))) begin
            state_d = StIdle;
          end else begin
            state_d   = StLoad;
            first_d   = 1'b1;
            rst_cnt_d = RstW'(RESET_CYCLES - 1);
          end
        end else begin
          if (beat) begin
            line_d = line_q + LineW'(1);
          end
          // Once draining, a re-raised enable cannot revive the run
          if (!cfg_enable) begin
            state_d = StDrain;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StIdle;
      line_q        <= '0;
      rst_cnt_q     <= '0;
      first_q       <= 1'b0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      gen_resetn_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      rst_cnt_q     <= rst_cnt_d;
      first_q       <= first_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      gen_resetn_q  <= (state_d == StRun) || (state_d == StDrain);
      busy_q        <= (state_d != StIdle);
    end
  end

  fractal_param_shadow u_shadow (
    .clk_i    (aclk),
    .rst_i    (areset),
    .update_i (cfg_update),
    .cfg_i    (cfg_set),
    .start_i  (start),
    .load_i   (first_q),
    .step_i   (boundary),
    .active_o (active)
  );

  assign gen_resetn  = gen_resetn_q;
  assign gen_x0      = active.x0;
  assign gen_y0      = active.y0;
  assign gen_dx      = active.dx;
  assign gen_dy      = active.dy;
  assign gen_cr      = active.cr;
  assign gen_ci      = active.ci;
  assign frame_count = frame_count_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fractal_frame_sequencer.sv
// Self-checking bench for fractal_frame_sequencer: per-cycle reference model plus
// table-driven frame runs, directed corner sequences and a randomized soak.
module tb_fractal_frame_sequencer;

  localparam int H  = 4;
  localparam int RC = 2;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_enable;
  logic        cfg_update;
  logic [31:0] cfg [8];
  logic [15:0] cfg_num_frames;
  logic        s_valid, s_ready, s_line_end;
  logic        gen_resetn;
  logic [31:0] gen_p [6];
  logic [15:0] frame_count;
  logic        frame_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state (index 0..7 = x0,y0,dx,dy,cr,ci,dcr,dci)
  bit          m_busy, m_first, m_stop, m_pend, m_done;
  int          m_left, m_lines;
  logic [15:0] m_fc;
  logic [31:0] sh  [8];
  logic [31:0] act [8];

  fractal_frame_sequencer #(
    .HEIGHT       (H),
    .RESET_CYCLES (RC),
    .FRAME_CNT_W  (16)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_enable     (cfg_enable),
    .cfg_update     (cfg_update),
    .cfg_x0         (cfg[0]),
    .cfg_y0         (cfg[1]),
    .cfg_dx         (cfg[2]),
    .cfg_dy         (cfg[3]),
    .cfg_cr         (cfg[4]),
    .cfg_ci         (cfg[5]),
    .cfg_dcr        (cfg[6]),
    .cfg_dci        (cfg[7]),
    .cfg_num_frames (cfg_num_frames),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_line_end     (s_line_end),
    .gen_resetn     (gen_resetn),
    .gen_x0         (gen_p[0]),
    .gen_y0         (gen_p[1]),
    .gen_dx         (gen_p[2]),
    .gen_dy         (gen_p[3]),
    .gen_cr         (gen_p[4]),
    .gen_ci         (gen_p[5]),
    .frame_count    (frame_count),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the behavioural model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit beat;
    beat   = s_valid && s_ready && s_line_end;
    m_done = 1'b0;
    if (areset) begin
      m_busy = 0; m_first = 0; m_stop = 0; m_pend = 0;
      m_left = 0; m_lines = 0; m_fc = '0;
      for (int i = 0; i < 8; i++) begin
        sh[i]  = '0;
        act[i] = '0;
      end
    end else begin
      if (!m_busy) begin
        if (cfg_enable) begin
          m_busy = 1; m_left = RC; m_first = 1; m_fc = '0;
          act[4] = sh[4];
          act[5] = sh[5];
        end
      end else if (m_left > 0) begin
        if (m_first) begin
          for (int i = 0; i < 8; i++) begin
            if (m_pend || i < 4 || i > 5) act[i] = sh[i];
          end
          m_pend  = 0;
          m_first = 0;
        end
        m_lines = 0;
        m_left--;
      end else begin
        if (!cfg_enable) m_stop = 1;
        if (beat) begin
          m_lines++;
          if (m_lines == H) begin
            m_lines = 0;
            m_done  = 1;
            m_fc    = m_fc + 16'd1;
            act[4]  = m_pend ? sh[4] : act[4] + act[6];
            act[5]  = m_pend ? sh[5] : act[5] + act[7];
            if (m_stop || (cfg_num_frames != 0 && m_fc == cfg_num_frames)) begin
              m_busy = 0;
              m_stop = 0;
            end else begin
              m_left  = RC;
              m_first = 1;
            end
          end
        end
      end
      if (cfg_update) begin
        for (int i = 0; i < 8; i++) sh[i] = cfg[i];
        m_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    model_step();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("gen_resetn", 32'(gen_resetn), 32'(m_busy && (m_left == 0)));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    for (int i = 0; i < 6; i++) chk($sformatf("gen_param%0d", i), gen_p[i], act[i]);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!gen_resetn && n < 20) begin
      tick();
      n++;
    end
    if (!gen_resetn) chk("wait_run timeout", 32'(gen_resetn), 32'd1);
  endtask

  task automatic send_beat();
    s_valid = 1; s_ready = 1; s_line_end = 1;
    tick();
    s_valid = 0; s_ready = 0; s_line_end = 0;
  endtask

  typedef struct {
    logic [15:0] nf;
    logic [31:0] cr, dcr, ci, dci;
    int          exp_frames;
    logic [31:0] exp_cr, exp_ci;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int   frames, low;
    bit   prev_rn, fin;
    vec_t v;

    vecs[0] = '{16'd3, 32'h100, 32'h10, 32'h200, 32'hFFFF_FFF8, 3, 32'h130, 32'h1E8};
    vecs[1] = '{16'd1, 32'h7FFF_FFF0, 32'h20, 32'h0, 32'h1, 1, 32'h8000_0010, 32'h1};
    vecs[2] = '{16'd2, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h0, 2, 32'h1, 32'h5};

    areset = 1; cfg_enable = 0; cfg_update = 0; cfg_num_frames = '0;
    s_valid = 0; s_ready = 0; s_line_end = 0;
    for (int i = 0; i < 8; i++) cfg[i] = 32'h1111_1111 * (i + 1);
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset gen_resetn", 32'(gen_resetn), 32'd0);
    chk("reset gen_cr", gen_p[4], 32'd0);
    areset = 0;
    tick();

    // Table-driven frame runs with continuous line beats
    for (int k = 0; k < 3; k++) begin
      v = vecs[k];
      cfg[0] = $urandom; cfg[1] = $urandom; cfg[2] = $urandom; cfg[3] = $urandom;
      cfg[4] = v.cr; cfg[5] = v.ci; cfg[6] = v.dcr; cfg[7] = v.dci;
      cfg_num_frames = v.nf;
      cfg_update = 1;
      tick();
      cfg_update = 0;
      cfg_enable = 1;
      s_valid = 1; s_ready = 1; s_line_end = 1;
      frames = 0; low = 0; prev_rn = 0; fin = 0;
      for (int c = 0; c < 100 && !fin; c++) begin
        tick();
        if (busy && !gen_resetn) low++;
        if (gen_resetn && !prev_rn) begin
          chk("load_len", 32'(low), 32'(RC));
          chk("frame_cr", gen_p[4], v.cr + 32'(frames) * v.dcr);
          low = 0;
        end
        prev_rn = gen_resetn;
        if (frame_done) begin
          frames++;
          if (frames == v.exp_frames) begin
            cfg_enable = 0;
            fin = 1;
          end
        end
      end
      chk("vec frames", 32'(frames), 32'(v.exp_frames));
      chk("vec end busy", 32'(busy), 32'd0);
      chk("vec end count", 32'(frame_count), 32'(v.exp_frames));
      chk("vec end cr", gen_p[4], v.exp_cr);
      chk("vec end ci", gen_p[5], v.exp_ci);
      s_valid = 0; s_ready = 0; s_line_end = 0;
      tick();
      chk("vec stays idle", 32'(busy), 32'd0);
    end

    // Stalled line_end beats do not count
    cfg_num_frames = '0;
    cfg_enable = 1;
    wait_run();
    s_valid = 1; s_ready = 0; s_line_end = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall no done", 32'(frame_done), 32'd0);
    end
    s_valid = 0; s_ready = 1;
    tick();
    chk("invalid no done", 32'(frame_done), 32'd0);
    for (int c = 0; c < H; c++) begin
      send_beat();
      chk("beat done", 32'(frame_done), 32'(c == H - 1));
    end

    // Enable dropped at line 1, re-raised at line 2: frame finishes and stops
    wait_run();
    send_beat();
    cfg_enable = 0;
    tick();
    cfg_enable = 1;
    send_beat();
    send_beat();
    send_beat();
    chk("drain done", 32'(frame_done), 32'd1);
    chk("drain idle", 32'(busy), 32'd0);
    chk("drain resetn", 32'(gen_resetn), 32'd0);
    cfg_enable = 0;
    tick();
    chk("drain stays idle", 32'(busy), 32'd0);

    // cfg_update on the boundary cycle restarts cr from the new base
    cfg[4] = 32'h40; cfg[6] = 32'h10;
    cfg_update = 1;
    tick();
    cfg_update = 0;
    cfg_enable = 1;
    wait_run();
    chk("base cr", gen_p[4], 32'h40);
    for (int c = 0; c < H - 1; c++) send_beat();
    cfg[4] = 32'h500;
    cfg_update = 1;
    send_beat();
    cfg_update = 0;
    chk("update boundary done", 32'(frame_done), 32'd1);
    wait_run();
    chk("new base cr", gen_p[4], 32'h500);
    for (int c = 0; c < H; c++) send_beat();
    wait_run();
    chk("new base step", gen_p[4], 32'h510);

    // Reset during line 2 aborts the frame silently
    send_beat();
    s_valid = 1; s_ready = 1; s_line_end = 1;
    areset = 1;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort resetn", 32'(gen_resetn), 32'd0);
    chk("abort done", 32'(frame_done), 32'd0);
    chk("abort count", 32'(frame_count), 32'd0);
    chk("abort cr", gen_p[4], 32'd0);
    areset = 0; cfg_enable = 0;
    s_valid = 0; s_ready = 0; s_line_end = 0;
    tick();
    chk("abort after done", 32'(frame_done), 32'd0);

    // Randomized soak against the model
    cfg_enable = 1;
    for (int c = 0; c < 2000; c++) begin
      areset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      cfg_update = ($urandom_range(0, 15) == 0);
      if (cfg_update) begin
        for (int i = 0; i < 8; i++) cfg[i] = $urandom;
        cfg_num_frames = 16'($urandom_range(0, 3));
      end
      s_valid    = ($urandom_range(0, 3) != 0);
      s_ready    = ($urandom_range(0, 3) != 0);
      s_line_end = ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/fractal_frame_sequencer.md
FRACTAL_FRAME_SEQUENCER -- requirements
Module: fractal_frame_sequencer

Interface
REQ-001 SHALL have parameter HEIGHT, default 1080, lines per frame (line_end beats before frame boundary).
REQ-002 SHALL have parameter RESET_CYCLES, default 2, cycles gen_resetn is held low at each frame boundary (>=1).
REQ-003 SHALL have parameter FRAME_CNT_W, default 16, width of frame counters.
REQ-004 SHALL have ports (clock and reset first), one per line:
  aclk  in  1  sole clock, all logic on rising edge
  areset  in  1  synchronous, active-high reset
  cfg_enable  in  1  level; 1 = run frames, 0 = stop after current frame
  cfg_update  in  1  pulse; capture all cfg_* values below into the shadow set
  cfg_x0, cfg_y0, cfg_dx, cfg_dy, cfg_cr, cfg_ci  in  32 each  signed Q-format base parameters
  cfg_dcr, cfg_dci  in  32 each  signed per-frame increments of cr/ci
  cfg_num_frames  in  FRAME_CNT_W  frames to run; 0 = unlimited
  s_valid, s_ready, s_line_end  in  1 each  monitored output-stream handshake of the generator
  gen_resetn  out  1  active-low reset to the generator
  gen_x0, gen_y0, gen_dx, gen_dy, gen_cr, gen_ci  out  32 each  active parameters to the generator
  frame_count  out  FRAME_CNT_W  frames completed since start
  frame_done  out  1  one-cycle pulse per completed frame
  busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN.
REQ-006 SHALL load shadow set from cfg_* on the cycle cfg_update=1; shadow SHALL be copied to active only in LOAD.
REQ-007 IDLE: gen_resetn=0; on cfg_enable=1 -> LOAD, frame_count cleared to 0, gen_cr/gen_ci := shadow base.
REQ-008 LOAD: gen_resetn=0 for exactly RESET_CYCLES cycles (down-counter); x0/y0/dx/dy/dcr/dci copied from shadow on first LOAD cycle; line counter cleared; then -> RUN.
REQ-009 RUN: gen_resetn=1; line counter increments on each cycle with s_valid & s_ready & s_line_end.
REQ-010 Frame boundary = line counter increment reaching HEIGHT: frame_done pulses the same cycle's next edge, frame_count increments (wraps modulo 2^FRAME_CNT_W).
REQ-011 At boundary: gen_cr += dcr, gen_ci += dci (32-bit two's-complement wrap); if cfg_update occurred since last LOAD, cr/ci SHALL instead restart from new shadow base.
REQ-012 At boundary: -> IDLE if cfg_enable=0 or (cfg_num_frames!=0 and new frame_count==cfg_num_frames); else -> LOAD.
REQ-013 cfg_enable falling in RUN -> DRAIN; DRAIN behaves as RUN but exits to IDLE at boundary; cfg_enable rising in DRAIN SHALL NOT cancel the stop.
REQ-014 cfg_update simultaneous with boundary SHALL be captured and applied in the following LOAD.
REQ-015 Beats with s_line_end but without s_valid & s_ready SHALL NOT count.
REQ-016 gen_* parameter outputs SHALL change only in LOAD or at a frame boundary, never while gen_resetn=1 mid-frame.
REQ-017 All outputs registered; frame_done latency 1 cycle after the counting handshake.

Reset
REQ-018 areset=1 SHALL force IDLE, gen_resetn=0, all gen_* =0, shadow=0, frame_count=0, frame_done=0, busy=0, counters=0.
REQ-019 areset mid-RUN SHALL abort the frame without a frame_done pulse.

Structure
REQ-020 Shared package fractal_pkg SHALL hold the state enum, the 32-bit parameter type, and the default HEIGHT/RESET_CYCLES constants.
REQ-021 One sub-module fractal_param_shadow (shadow+active register set with update-pending flag) is natural; FSM and counters stay in the top.

Verification (HEIGHT=4, RESET_CYCLES=2)
REQ-022 Enable with num_frames=3, cr=0x100, dcr=0x10 -> three LOAD/RUN cycles, gen_cr 0x100, 0x110, 0x120, frame_count=3, then IDLE, busy=0.
REQ-023 Each LOAD -> gen_resetn low exactly 2 cycles; 4 counted line_end beats -> one frame_done pulse.
REQ-024 line_end with s_ready=0 for 5 cycles -> line counter unchanged, no frame_done.
REQ-025 cfg_enable dropped after line 1, re-raised at line 2 -> frame completes, IDLE entered, gen_resetn=0.
REQ-026 cfg_update with cr=0x500 on the boundary cycle -> next frame gen_cr=0x500, not base+dcr.
REQ-027 areset during line 2 of RUN -> next cycle IDLE, all outputs 0, no frame_done.
